// File: rtl/ofdm_pkg.sv
// Shared constants for the OFDM framer: FSM encoding, default carrier map, bin-index bit reversal.
package ofdm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_UNLOAD = 2'd3;

  // Four 4-bit bin indices {7,3,1,0}, entry 0 in the LSBs.
  localparam logic [15:0] DEF_CARRIER_MAP = 16'h7310;

  // Widest bin index supported (64 points).
  localparam int MAX_LW = 6;

  // Reverses the low w bits of v; bits at or above w come back as zero.
  function automatic logic [MAX_LW-1:0] bitrev(input logic [MAX_LW-1:0] v, input int w);
    logic [MAX_LW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LW; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ofdm_bin_buf.sv
// PTS-entry re/im register bank: clear-all, one write port (write beats clear), flat parallel read.
// Write visible one cycle after wr_en; no backpressure.
module ofdm_bin_buf #(
  parameter int N   = 16,
  parameter int PTS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [$clog2(PTS)-1:0]     wr_addr,
  input  logic [N-1:0]               wr_re,
  input  logic [N-1:0]               wr_im,
  output logic [PTS*N-1:0]           rd_re,
  output logic [PTS*N-1:0]           rd_im
);

  localparam int LW = $clog2(PTS);

  logic [PTS*N-1:0] bank_re;
  logic [PTS*N-1:0] bank_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_re <= '0;
      bank_im <= '0;
    end else begin
      for (int k = 0; k < PTS; k++) begin
        if (wr_en && (wr_addr == LW'(k))) begin
          bank_re[k*N +: N] <= wr_re;
          bank_im[k*N +: N] <= wr_im;
        end else if (clr) begin
          bank_re[k*N +: N] <= '0;
          bank_im[k*N +: N] <= '0;
        end
      end
    end
  end

  assign rd_re = bank_re;
  assign rd_im = bank_im;

endmodule

// File: rtl/ofdm_fft_framer.sv
// Gathers NCH subcarrier symbols into PTS FFT bins, hands them to an external FFT, then streams the
// result in natural order. s_ready drops from FFT start until the last output handshake; m_* hold while stalled.
module ofdm_fft_framer
  import ofdm_pkg::*;
#(
  parameter int N   = 16,
  parameter int Q   = 8,
  parameter int PTS = 16,
  parameter int NCH = 4,
  parameter logic [NCH*$clog2(PTS)-1:0] CARRIER_MAP = DEF_CARRIER_MAP,
  parameter bit BITREV = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_inverse,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [N-1:0]               s_re,
  input  logic [N-1:0]               s_im,
  output logic                       o_fft_start,
  output logic [PTS*N-1:0]           o_fft_in_re,
  output logic [PTS*N-1:0]           o_fft_in_im,
  input  logic                       i_fft_done,
  input  logic [PTS*N-1:0]           i_fft_out_re,
  input  logic [PTS*N-1:0]           i_fft_out_im,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N-1:0]               m_re,
  output logic [N-1:0]               m_im,
  output logic [$clog2(PTS)-1:0]     m_idx,
  output logic                       m_last,
  output logic                       o_busy
);

  localparam int LW = $clog2(PTS);
  localparam int CW = $clog2(NCH) + 1;

  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("ofdm_fft_framer: Q must lie in 0..N-1");
  end
  if (PTS < 8 || PTS > 64 || (PTS & (PTS - 1)) != 0) begin : g_bad_pts
    $error("ofdm_fft_framer: PTS must be a power of two in 8..64");
  end
  if (NCH < 1 || NCH > PTS) begin : g_bad_nch
    $error("ofdm_fft_framer: NCH must lie in 1..PTS");
  end

  // Async assert, two-flop synchronised release; everything below resets on the synchronised copy.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  logic [1:0]       state;
  logic             inv_q;
  logic [CW-1:0]    ld_cnt;
  logic [LW-1:0]    out_cnt;
  logic             fft_start_q;
  logic [PTS*N-1:0] res_re;
  logic [PTS*N-1:0] res_im;

  logic             acc;
  logic             inv_now;
  logic [CW-1:0]    ld_sel;
  logic             last_in;
  logic [LW-1:0]    wr_addr;
  logic [N-1:0]     wr_re;
  logic [N-1:0]     wr_im;
  logic             bin_clr;

  assign s_ready = rst_n_int && ((state == ST_IDLE) || (state == ST_LOAD));
  assign acc     = s_valid && s_ready;

  // The mode is taken live on the first sample and from the latch for the rest of the symbol.
  assign inv_now = (state == ST_IDLE) ? i_inverse : inv_q;
  assign ld_sel  = (state == ST_IDLE) ? '0 : ld_cnt;
  assign last_in = (ld_sel == CW'(NCH - 1));
  assign wr_addr = CARRIER_MAP[int'(ld_sel)*LW +: LW];
  assign wr_re   = inv_now ? s_im : s_re;
  assign wr_im   = inv_now ? s_re : s_im;
  assign bin_clr = acc && (state == ST_IDLE);

  ofdm_bin_buf #(
    .N   (N),
    .PTS (PTS)
  ) u_bin_buf (
    .clk     (i_clk),
    .rst_n   (rst_n_int),
    .clr     (bin_clr),
    .wr_en   (acc),
    .wr_addr (wr_addr),
    .wr_re   (wr_re),
    .wr_im   (wr_im),
    .rd_re   (o_fft_in_re),
    .rd_im   (o_fft_in_im)
  );

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state       <= ST_IDLE;
      inv_q       <= 1'b0;
      ld_cnt      <= '0;
      out_cnt     <= '0;
      fft_start_q <= 1'b0;
      res_re      <= '0;
      res_im      <= '0;
    end else begin
      fft_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc) begin
            inv_q <= i_inverse;
            if (last_in) begin
              state       <= ST_RUN;
              fft_start_q <= 1'b1;
              ld_cnt      <= '0;
            end else begin
              state  <= ST_LOAD;
              ld_cnt <= CW'(1);
            end
          end
        end
        ST_LOAD: begin
          if (acc) begin
            if (last_in) begin
              state       <= ST_RUN;
              fft_start_q <= 1'b1;
              ld_cnt      <= '0;
            end else begin
              ld_cnt <= ld_cnt + CW'(1);
            end
          end
        end
        ST_RUN: begin
          if (i_fft_done) begin
            res_re <= i_fft_out_re;
            res_im <= i_fft_out_im;
            state  <= ST_UNLOAD;
          end
        end
        default: begin
          if (m_ready) begin
            if (out_cnt == LW'(PTS - 1)) begin
              state   <= ST_IDLE;
              out_cnt <= '0;
            end else begin
              out_cnt <= out_cnt + LW'(1);
            end
          end
        end
      endcase
    end
  end

  assign o_fft_start = fft_start_q;

  logic [MAX_LW-1:0] cnt_ext;
  logic [MAX_LW-1:0] rd_sel;
  logic [N-1:0]      rd_re;
  logic [N-1:0]      rd_im;

  // The external FFT delivers bins in bit-reversed order; reading through bitrev restores natural order.
  assign cnt_ext = MAX_LW'(out_cnt);
  assign rd_sel  = BITREV ? bitrev(cnt_ext, LW) : cnt_ext;
  assign rd_re   = res_re[int'(rd_sel)*N +: N];
  assign rd_im   = res_im[int'(rd_sel)*N +: N];

  assign m_valid = (state == ST_UNLOAD);
  assign m_re    = m_valid ? (inv_q ? rd_im : rd_re) : '0;
  assign m_im    = m_valid ? (inv_q ? rd_re : rd_im) : '0;
  assign m_idx   = out_cnt;
  assign m_last  = m_valid && (out_cnt == LW'(PTS - 1));
  assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_ofdm_fft_framer.sv
// Directed bench for ofdm_fft_framer: default bit-reversed instance plus a BITREV=0 twin on the same stimulus.
module tb_ofdm_fft_framer;

  localparam int N   = 16;
  localparam int PTS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inverse = 1'b0;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic [N-1:0] s_re = '0;
  logic [N-1:0] s_im = '0;
  logic stub_done = 1'b0;
  logic spur_done = 1'b0;
  logic fft_done;
  logic [PTS*N-1:0] fft_re;
  logic [PTS*N-1:0] fft_im;

  logic s_ready, fft_start, m_valid, m_last, busy;
  logic [PTS*N-1:0] fin_re, fin_im;
  logic [N-1:0] m_re, m_im;
  logic [3:0] m_idx;

  logic n_s_ready, n_fft_start, n_m_valid, n_m_last, n_busy;
  logic [PTS*N-1:0] n_fin_re, n_fin_im;
  logic [N-1:0] n_m_re, n_m_im;
  logic [3:0] n_m_idx;

  int ncmp = 0;
  int nerr = 0;
  int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int e_re[16];
  int e_im[16];

  assign fft_done = stub_done | spur_done;

  always #5 clk = ~clk;

  ofdm_fft_framer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inverse(inverse),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .o_fft_start(fft_start), .o_fft_in_re(fin_re), .o_fft_in_im(fin_im),
    .i_fft_done(fft_done), .i_fft_out_re(fft_re), .i_fft_out_im(fft_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_last(m_last), .o_busy(busy)
  );

  ofdm_fft_framer #(.BITREV(1'b0)) dut_nat (
    .i_clk(clk), .i_rst_n(rst_n), .i_inverse(inverse),
    .s_valid(s_valid), .s_ready(n_s_ready), .s_re(s_re), .s_im(s_im),
    .o_fft_start(n_fft_start), .o_fft_in_re(n_fin_re), .o_fft_in_im(n_fin_im),
    .i_fft_done(fft_done), .i_fft_out_re(fft_re), .i_fft_out_im(fft_im),
    .m_valid(n_m_valid), .m_ready(m_ready), .m_re(n_m_re), .m_im(n_m_im),
    .m_idx(n_m_idx), .m_last(n_m_last), .o_busy(n_busy)
  );

  // Stub FFT: done pulse five cycles after the start pulse.
  initial forever begin
    @(negedge clk);
    if (fft_start) begin
      repeat (5) @(negedge clk);
      stub_done = 1'b1;
      @(negedge clk);
      stub_done = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int s16(input int v);
    return v & 32'h0000_FFFF;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int re, input int im);
    s_valid = 1'b1;
    s_re = 16'(re);
    s_im = 16'(im);
    for (int k = 0; k < 20 && !s_ready; k++) @(negedge clk);
    chk("s_ready_accept", int'(s_ready), 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 16; k++) begin
      e_re[k] = 0;
      e_im[k] = 0;
    end
  endtask

  task automatic chk_bins();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("bin%0d_re", k), int'(fin_re[k*N +: N]), s16(e_re[k]));
      chk($sformatf("bin%0d_im", k), int'(fin_im[k*N +: N]), s16(e_im[k]));
    end
  endtask

  task automatic wait_mvalid();
    for (int k = 0; k < 40 && !m_valid; k++) @(negedge clk);
    chk("m_valid_wait", int'(m_valid), 1);
  endtask

  task automatic set_ramp_result();
    for (int k = 0; k < PTS; k++) begin
      fft_re[k*N +: N] = 16'(k);
      fft_im[k*N +: N] = 16'(k + 100);
    end
  endtask

  task automatic stream(input int mode);
    for (int i = 0; i < PTS; i++) begin
      chk("m_valid", int'(m_valid), 1);
      chk("m_idx", int'(m_idx), i);
      chk("m_last", int'(m_last), int'(i == PTS - 1));
      chk("s_ready_unload", int'(s_ready), 0);
      if (mode == 0) begin
        chk("m_re_bitrev", int'(m_re), br[i]);
        chk("m_im_bitrev", int'(m_im), br[i] + 100);
        chk("nat_m_re", int'(n_m_re), i);
      end else begin
        chk("inv_m_re", int'(m_re), 7);
        chk("inv_m_im", int'(m_im), 3);
        chk("nat_inv_m_re", int'(n_m_re), 7);
      end
      @(negedge clk);
    end
    chk("idle_after_busy", int'(busy), 0);
    chk("idle_after_valid", int'(m_valid), 0);
  endtask

  initial begin
    int e;
    bit tog;
    set_ramp_result();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_fft_start", int'(fft_start), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_bins_zero", int'(|{fin_re, fin_im}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_s_ready", int'(s_ready), 1);
    chk("post_rst_busy", int'(busy), 0);

    // Forward symbol onto bins 0,1,3,7
    send(256, 0);
    send(0, 256);
    send(-256, 0);
    send(0, -256);
    chk("start_pulse", int'(fft_start), 1);
    chk("run_busy", int'(busy), 1);
    chk("run_s_ready", int'(s_ready), 0);
    clear_exp();
    e_re[0] = 256; e_im[1] = 256; e_re[3] = -256; e_im[7] = -256;
    chk_bins();
    @(negedge clk);
    chk("start_single", int'(fft_start), 0);
    m_ready = 1'b1;
    wait_mvalid();
    stream(0);

    // Spurious done in IDLE, then in LOAD
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("spur_idle_busy", int'(busy), 0);
    chk("spur_idle_valid", int'(m_valid), 0);
    send(1, 1);
    send(2, 2);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    chk("spur_load_busy", int'(busy), 1);
    chk("spur_load_s_ready", int'(s_ready), 1);
    chk("spur_load_valid", int'(m_valid), 0);
    send(3, 3);
    send(4, 4);

    // m_ready toggling every cycle
    m_ready = 1'b0;
    wait_mvalid();
    e = 0;
    tog = 1'b0;
    for (int cyc = 0; cyc < 64 && e < 16; cyc++) begin
      chk("tog_valid", int'(m_valid), 1);
      chk("tog_idx", int'(m_idx), e);
      chk("tog_re", int'(m_re), br[e]);
      chk("tog_last", int'(m_last), int'(e == 15));
      chk("tog_s_ready", int'(s_ready), 0);
      m_ready = tog;
      if (tog) e++;
      tog = ~tog;
      @(negedge clk);
    end
    chk("tog_count", e, 16);
    m_ready = 1'b0;
    chk("tog_idle", int'(busy), 0);

    // Inverse mode: swap on write and on read; mode latched from the first sample
    for (int k = 0; k < PTS; k++) begin
      fft_re[k*N +: N] = 16'(3);
      fft_im[k*N +: N] = 16'(7);
    end
    inverse = 1'b1;
    send(100, -50);
    inverse = 1'b0;
    send(1, 2);
    send(3, 4);
    send(5, 6);
    clear_exp();
    e_re[0] = -50; e_im[0] = 100;
    e_re[1] = 2;   e_im[1] = 1;
    e_re[3] = 4;   e_im[3] = 3;
    e_re[7] = 6;   e_im[7] = 5;
    chk_bins();
    m_ready = 1'b1;
    wait_mvalid();
    stream(1);

    // Reset two samples into LOAD
    set_ramp_result();
    send(11, 12);
    send(13, 14);
    rst_n = 1'b0;
    #1;
    chk("rl_busy", int'(busy), 0);
    chk("rl_valid", int'(m_valid), 0);
    chk("rl_start", int'(fft_start), 0);
    chk("rl_last", int'(m_last), 0);
    chk("rl_bins_zero", int'(|{fin_re, fin_im}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rl_s_ready", int'(s_ready), 1);
    chk("rl_busy_after", int'(busy), 0);

    // Fresh symbol, then reset at output index 5
    send(10, 20);
    send(30, 40);
    send(50, 60);
    send(70, 80);
    clear_exp();
    e_re[0] = 10; e_im[0] = 20;
    e_re[1] = 30; e_im[1] = 40;
    e_re[3] = 50; e_im[3] = 60;
    e_re[7] = 70; e_im[7] = 80;
    chk_bins();
    wait_mvalid();
    for (int k = 0; k < 10 && m_idx != 4'd5; k++) @(negedge clk);
    chk("ru_at_idx5", int'(m_idx), 5);
    rst_n = 1'b0;
    #1;
    chk("ru_valid", int'(m_valid), 0);
    chk("ru_busy", int'(busy), 0);
    chk("ru_last", int'(m_last), 0);
    chk("ru_m_re", int'(m_re), 0);
    chk("ru_m_idx", int'(m_idx), 0);
    chk("ru_bins_zero", int'(|{fin_re, fin_im}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("ru_discard_valid", int'(m_valid), 0);
    chk("ru_s_ready", int'(s_ready), 1);

    // Next symbol carries only its own data
    send(5, 6);
    send(7, 8);
    send(9, 10);
    send(11, 12);
    clear_exp();
    e_re[0] = 5;  e_im[0] = 6;
    e_re[1] = 7;  e_im[1] = 8;
    e_re[3] = 9;  e_im[3] = 10;
    e_re[7] = 11; e_im[7] = 12;
    chk_bins();
    wait_mvalid();
    stream(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ofdm_fft_framer.md
OFDM_FFT_FRAMER -- requirements
Module: ofdm_fft_framer

Interface
REQ-001 Parameters SHALL be: N, default 16, sample width (signed, Q fractional bits); Q, default 8, fractional bits; PTS, default 16, FFT points (power of 2, 8..64); NCH, default 4, active subcarriers (1..PTS); CARRIER_MAP, default {7,3,1,0}, NCH packed log2(PTS)-bit bin indices, entry 0 in LSBs; BITREV, default 1, output reorder: 1 = bit-reversed FFT index to natural, 0 = pass-through.
REQ-002 Ports SHALL be, clock and reset first: i_clk in 1 clock; i_rst_n in 1 async active-low reset; i_inverse in 1 IFFT mode, sampled at symbol start; s_valid in 1; s_ready out 1; s_re, s_im in N subcarrier symbol; o_fft_start out 1 pulse; o_fft_in_re, o_fft_in_im out PTS*N bin vector, bin k at [k*N +: N]; i_fft_done in 1 pulse; i_fft_out_re, i_fft_out_im in PTS*N; m_valid out 1; m_ready in 1; m_re, m_im out N; m_idx out log2(PTS) natural bin index; m_last out 1; o_busy out 1.
REQ-003 One clock domain; reset asynchronous, active-low, as already decided.

Function
REQ-004 FSM SHALL have states IDLE, LOAD, RUN, UNLOAD.
REQ-005 IDLE: s_ready=1; first s_valid&s_ready SHALL latch i_inverse, clear all PTS bins to 0, write sample to bin CARRIER_MAP[0], go LOAD (or RUN if NCH=1).
REQ-006 LOAD: s_ready=1; j-th accepted sample SHALL be written to bin CARRIER_MAP[j]; after NCH-th acceptance go RUN.
REQ-007 In inverse mode input re/im SHALL be swapped on write and output re/im swapped on read (swap-IFFT); no scaling.
REQ-008 o_fft_start SHALL pulse exactly one cycle, the cycle after entering RUN; o_fft_in_* SHALL be stable from that pulse until i_fft_done.
REQ-009 RUN: s_ready=0; i_fft_done SHALL capture i_fft_out_* into result registers and go UNLOAD next cycle; i_fft_done in any other state SHALL be ignored.
REQ-010 UNLOAD: m_valid=1; output counter c SHALL run 0..PTS-1, advancing only on m_valid&m_ready; m_idx=c; m_re/m_im = result[BITREV ? bitrev(c) : c].
REQ-011 m_last SHALL equal (c==PTS-1) while m_valid; handshake on m_last SHALL return to IDLE; with m_ready held 1, PTS output cycles per symbol.
REQ-012 m_* SHALL hold stable while m_valid&!m_ready.
REQ-013 o_busy SHALL be 1 in every state except IDLE.
REQ-014 Duplicate CARRIER_MAP entries: later write wins (not an error).
REQ-015 s_ready SHALL be 0 in RUN and UNLOAD; inputs are never dropped.

Reset
REQ-016 On i_rst_n=0, regardless of state: FSM to IDLE; all bins, results, counters zero; o_fft_start, m_valid, m_last, o_busy =0; s_ready=1 after deassertion; pending FFT result discarded.
REQ-017 Reset deassertion SHALL be synchronised internally (2-flop) before FSM leaves IDLE.

Structure
REQ-018 Package ofdm_pkg SHALL hold FSM state encoding, bitrev function, and default CARRIER_MAP constant.
REQ-019 Sub-module ofdm_bin_buf SHALL hold PTS-entry re/im register bank with clear-all, single write port, flattened parallel read.
REQ-020 FFT core SHALL be external; block contains no arithmetic beyond swap.

Verification
REQ-021 Defaults, i_inverse=0, inputs (256,0),(0,256),(-256,0),(0,-256): o_fft_in bins 0,1,3,7 hold them, others 0; o_fft_start single pulse one cycle after 4th acceptance.
REQ-022 Stub FFT returning result[k]=k (re), done 5 cycles later; m_ready=1: m_re sequence 0,8,4,12,2,... (bitrev), m_idx 0..15, m_last at idx 15; BITREV=0 gives 0..15.
REQ-023 i_inverse=1, input (100,-50): bin holds (-50,100); stub result (3,7) out as (7,3).
REQ-024 m_ready toggled 1/0 every cycle: 16 handshakes, no repeated/skipped idx, outputs stable when stalled; s_ready=0 throughout.
REQ-025 i_rst_n asserted mid-LOAD (2 samples in) and mid-UNLOAD (idx 5): all outputs zero, next symbol bins contain no stale data.
REQ-026 Spurious i_fft_done in IDLE and LOAD: no state change, no m_valid.
